// File: rtl/mask_encoder_serial.sv
`default_nettype none
// ============================================================================
// Module      : mask_encoder_serial
// Description : Serialises a multi-hot request mask into one binary index per
//               set bit (fixed priority or round-robin), valid/ready both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_encoder_serial #(
  parameter int N       = 4,
  parameter int W       = $clog2(N),
  parameter bit RR_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] mask,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last,
  output logic         zero_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [W-1:0] c_last_idx = W'(N - 1);

  state_t       r_state;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_rr_ptr;

  logic [N-1:0] w_code_onehot;
  logic [N-1:0] w_cleared;
  logic [W-1:0] w_next_ptr;
  logic [N-1:0] w_src;
  logic [W-1:0] w_ptr_src;
  logic [W-1:0] w_sel;
  logic         w_single;

  assign in_ready = reset && (r_state == IDLE);

  always_comb begin
    w_code_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_code_onehot[i] = (code == W'(i));
    end
  end

  assign w_cleared  = r_pending & ~w_code_onehot;
  assign w_next_ptr = (code == c_last_idx) ? '0 : code + W'(1);

  // The registered code/last always describe the next bit to present: either
  // the freshly accepted mask or what remains after the current transfer.
  assign w_src     = (r_state == IDLE) ? mask : w_cleared;
  assign w_ptr_src = (r_state == IDLE || !RR_MODE) ? r_rr_ptr : w_next_ptr;

  always_comb begin
    logic       found;
    logic [W-1:0] idx;
    int         j;
    w_sel = '0;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    if (RR_MODE) begin
      for (int k = 0; k < N; k++) begin
        j = int'(w_ptr_src) + k;
        if (j >= N) j = j - N;
        idx = W'(j);
        if (!found && w_src[idx]) begin
          w_sel = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_src[i]) w_sel = W'(i);
      end
    end
  end

  assign w_single = (w_src != '0) && ((w_src & (w_src - N'(1))) == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_rr_ptr  <= '0;
      code      <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      zero_err  <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (mask == '0) begin
              zero_err <= 1'b1;
            end else begin
              r_pending <= mask;
              code      <= w_sel;
              last      <= w_single;
              out_valid <= 1'b1;
              r_state   <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_pending <= w_cleared;
            if (RR_MODE) r_rr_ptr <= w_next_ptr;
            if (w_cleared == '0) begin
              out_valid <= 1'b0;
              last      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              code <= w_sel;
              last <= w_single;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_encoder_serial.sv
`default_nettype none
// Bench for mask_encoder_serial: fixed-priority and round-robin instances
// share stimulus and are checked against a queue-based reference model.
module tb_mask_encoder_serial;

  logic       clk;
  logic       reset;
  logic [3:0] mask;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, out_valid0, last0, zero_err0;
  logic [1:0] code0;
  logic       in_ready1, out_valid1, last1, zero_err1;
  logic [1:0] code1;

  int checks   = 0;
  int failures = 0;

  int q0[$];
  int q1[$];
  int mptr = 0;

  mask_encoder_serial #(.N(4), .W(2), .RR_MODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .mask(mask), .in_valid(in_valid),
    .in_ready(in_ready0), .code(code0), .out_valid(out_valid0),
    .out_ready(out_ready), .last(last0), .zero_err(zero_err0)
  );

  mask_encoder_serial #(.N(4), .W(2), .RR_MODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .mask(mask), .in_valid(in_valid),
    .in_ready(in_ready1), .code(code1), .out_valid(out_valid1),
    .out_ready(out_ready), .last(last1), .zero_err(zero_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected emission order: fixed = descending set indices;
  // round-robin = repeatedly take the first set index at/after the pointer.
  task automatic build_expected(input logic [3:0] m);
    logic [3:0] rem;
    q0.delete();
    q1.delete();
    for (int i = 3; i >= 0; i--) if (m[i]) q0.push_back(i);
    rem = m;
    while (rem != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (mptr + k) % 4;
        if (rem[j]) begin
          q1.push_back(j);
          rem[j] = 1'b0;
          mptr = (j + 1) % 4;
          break;
        end
      end
    end
  endtask

  task automatic accept_mask(input logic [3:0] m);
    int t;
    t = 0;
    while (!in_ready0 && t < 20) begin
      step();
      t++;
    end
    checks++;
    if (!in_ready0 || !in_ready1) begin
      failures++;
      $display("FAIL accept_wait: in_ready0=%0b in_ready1=%0b required 1", in_ready0, in_ready1);
    end
    mask = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_present(input string name);
    checks++;
    if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid: out_valid=%0b/%0b in_ready=%0b/%0b required 1/1 0/0",
               name, out_valid0, out_valid1, in_ready0, in_ready1);
    end
    checks++;
    if (code0 !== 2'(q0[0]) || last0 !== (q0.size() == 1)) begin
      failures++;
      $display("FAIL %s_fixed: code=%0d last=%0b required code=%0d last=%0b",
               name, code0, last0, q0[0], q0.size() == 1);
    end
    checks++;
    if (code1 !== 2'(q1[0]) || last1 !== (q1.size() == 1)) begin
      failures++;
      $display("FAIL %s_rr: code=%0d last=%0b required code=%0d last=%0b",
               name, code1, last1, q1[0], q1.size() == 1);
    end
  endtask

  task automatic check_idle_after(input string name);
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle: out_valid=%0b/%0b in_ready=%0b/%0b required 0/0 1/1",
               name, out_valid0, out_valid1, in_ready0, in_ready1);
    end
  endtask

  task automatic run_mask(input logic [3:0] m, input int stall_pct, input bit garbage);
    int budget;
    build_expected(m);
    accept_mask(m);
    if (m == 4'b0000) begin
      checks++;
      if (zero_err0 !== 1'b1 || zero_err1 !== 1'b1 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL zero_pulse: zero_err=%0b/%0b out_valid=%0b/%0b required 1/1 0/0",
                 zero_err0, zero_err1, out_valid0, out_valid1);
      end
      step();
      checks++;
      if (zero_err0 !== 1'b0 || zero_err1 !== 1'b0 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL zero_once: zero_err=%0b/%0b out_valid=%0b/%0b required 0/0 0/0",
                 zero_err0, zero_err1, out_valid0, out_valid1);
      end
      return;
    end
    checks++;
    if (zero_err0 !== 1'b0 || zero_err1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_spurious: zero_err=%0b/%0b required 0/0", zero_err0, zero_err1);
    end
    budget = 0;
    while (q0.size() > 0 && budget < 200) begin
      check_present("emit");
      out_ready = ($urandom_range(99) >= stall_pct);
      if (garbage) begin
        in_valid = 1'b1;
        mask = 4'($urandom_range(15));
      end
      step();
      if (out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      budget++;
    end
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL emit_timeout: remaining=%0d required 0", q0.size());
    end
    check_idle_after("emit_end");
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0 ||
        code0 !== 2'd0 || code1 !== 2'd0 || last0 !== 1'b0 || zero_err0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%0b/%0b in_ready=%0b/%0b code=%0d/%0d last=%0b zero_err=%0b required 0",
               out_valid0, out_valid1, in_ready0, in_ready1, code0, code1, last0, zero_err0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: in_ready=%0b/%0b required 1/1", in_ready0, in_ready1);
    end
    mptr = 0;
    step();
  endtask

  task automatic test_directed();
    run_mask(4'b1011, 0, 1'b0);
    run_mask(4'b1010, 0, 1'b0);
    run_mask(4'b1111, 0, 1'b0);
    run_mask(4'b0010, 0, 1'b0);
    run_mask(4'b0011, 0, 1'b0);
  endtask

  task automatic test_stall();
    build_expected(4'b0100);
    out_ready = 1'b0;
    accept_mask(4'b0100);
    for (int c = 0; c < 5; c++) begin
      check_present("stall");
      step();
    end
    out_ready = 1'b1;
    check_present("stall_release");
    step();
    check_idle_after("stall_end");
  endtask

  task automatic test_zero();
    run_mask(4'b0000, 0, 1'b0);
    run_mask(4'b0001, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    build_expected(4'b1111);
    out_ready = 1'b1;
    accept_mask(4'b1111);
    for (int c = 0; c < 2; c++) begin
      check_present("mid");
      step();
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    reset = 1'b0;
    step();
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || last0 !== 1'b0 || last1 !== 1'b0 ||
        in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: out_valid=%0b/%0b last=%0b/%0b in_ready=%0b/%0b required all 0",
               out_valid0, out_valid1, last0, last1, in_ready0, in_ready1);
    end
    reset = 1'b1;
    mptr = 0;
    #1;
    run_mask(4'b1111, 0, 1'b0);
    run_mask(4'b0110, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_mask(4'($urandom_range(15)), 35, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      run_mask(4'($urandom_range(15)), 20, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0;
    mask = 4'b0000;
    in_valid = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_zero();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
